rtc_sync_core: RTL

RTC-domain timekeeping core running entirely on `rtc_clk`. It receives bus-initiated register writes over a two-phase toggle handshake and publishes stable counter snapshots to the bus domain over a second two-phase toggle handshake. The bus-clock side of both handshakes lives in the bus-domain RTC wrapper. This block is the rtc_clk-side responder for writes and the transmitter for reads.

---
 rtl/rtc_sync_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rtc_sync_core.sv
// RTC-domain timekeeping core: toggle-handshake write responder and counter snapshot publisher.
// Alarm compare, sticky flag and interrupt are built only when `RTC_ALARM_EN is defined.
module rtc_sync_core #(
  parameter int unsigned IO_MAP_WIDTH = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    rtc_clk,
  input  logic                    rst,
  input  logic                    wr_req_tgl,
  input  logic [1:0]              wr_sel,
  input  logic [IO_MAP_WIDTH-1:0] wr_data,
  output logic                    wr_ack_tgl,
  output logic [IO_MAP_WIDTH-1:0] snap_data,
  output logic                    snap_tgl,
  input  logic                    snap_ack_tgl,
  output logic                    alarm_irq
);

  localparam logic [1:0] SEL_CNT  = 2'd0;
  localparam logic [1:0] SEL_CTRL = 2'd2;
`ifdef RTC_ALARM_EN
  localparam logic [1:0] SEL_ALARM = 2'd1;
`endif

  typedef enum logic {W_IDLE, W_APPLY} w_state_e;
  typedef enum logic {S_PUB, S_WAIT} s_state_e;

  w_state_e w_state_q, w_state_d;
  s_state_e s_state_q, s_state_d;

  logic [SYNC_STAGES-1:0]  req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;
  logic                    req_seen_q, req_seen_d;
  logic [1:0]              hold_sel_q, hold_sel_d;
  logic [IO_MAP_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [IO_MAP_WIDTH-1:0] cnt_q, cnt_d;
  logic                    cnt_en_q, cnt_en_d;
  logic                    wr_ack_q, wr_ack_d;
  logic [IO_MAP_WIDTH-1:0] snap_data_q, snap_data_d;
  logic                    snap_tgl_q, snap_tgl_d;

`ifdef RTC_ALARM_EN
  logic [IO_MAP_WIDTH-1:0] alarm_cmp_q, alarm_cmp_d;
  logic                    alarm_flag_q, alarm_flag_d;
  logic                    irq_en_q, irq_en_d;
`endif

  logic req_sync;
  logic ack_sync;
  logic req_new;
  logic apply;

  assign req_sync = req_sync_q[SYNC_STAGES-1];
  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign req_new  = (w_state_q == W_IDLE) && (req_sync != req_seen_q);
  assign apply    = (w_state_q == W_APPLY);

  // State register for both FSMs and all datapath flops
  always_ff @(posedge rtc_clk or posedge rst) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      s_state_q    <= S_PUB;
      req_sync_q   <= '0;
      ack_sync_q   <= '0;
      req_seen_q   <= 1'b0;
      hold_sel_q   <= '0;
      hold_data_q  <= '0;
      cnt_q        <= '0;
      cnt_en_q     <= 1'b1;
      wr_ack_q     <= 1'b0;
      snap_data_q  <= '0;
      snap_tgl_q   <= 1'b0;
`ifdef RTC_ALARM_EN
      alarm_cmp_q  <= '1;
      alarm_flag_q <= 1'b0;
      irq_en_q     <= 1'b0;
`endif
    end else begin
      w_state_q    <= w_state_d;
      s_state_q    <= s_state_d;
      req_sync_q   <= req_sync_d;
      ack_sync_q   <= ack_sync_d;
      req_seen_q   <= req_seen_d;
      hold_sel_q   <= hold_sel_d;
      hold_data_q  <= hold_data_d;
      cnt_q        <= cnt_d;
      cnt_en_q     <= cnt_en_d;
      wr_ack_q     <= wr_ack_d;
      snap_data_q  <= snap_data_d;
      snap_tgl_q   <= snap_tgl_d;
`ifdef RTC_ALARM_EN
      alarm_cmp_q  <= alarm_cmp_d;
      alarm_flag_q <= alarm_flag_d;
      irq_en_q     <= irq_en_d;
`endif
    end
  end

  // Next-state logic for the write and snapshot FSMs
  always_comb begin
    w_state_d = w_state_q;
    s_state_d = s_state_q;
    case (w_state_q)
      W_IDLE:  if (req_new) w_state_d = W_APPLY;
      W_APPLY: w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (s_state_q)
      S_PUB:   s_state_d = S_WAIT;
      S_WAIT:  if (ack_sync == snap_tgl_q) s_state_d = S_PUB;
      default: s_state_d = S_PUB;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], wr_req_tgl};
    ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], snap_ack_tgl};
    req_seen_d  = req_seen_q;
    hold_sel_d  = hold_sel_q;
    hold_data_d = hold_data_q;
    cnt_d       = cnt_en_q ? cnt_q + IO_MAP_WIDTH'(1) : cnt_q;
    cnt_en_d    = cnt_en_q;
    wr_ack_d    = wr_ack_q;
    snap_data_d = snap_data_q;
    snap_tgl_d  = snap_tgl_q;
`ifdef RTC_ALARM_EN
    alarm_cmp_d  = alarm_cmp_q;
    irq_en_d     = irq_en_q;
    alarm_flag_d = alarm_flag_q;
`endif

    if (req_new) begin
      hold_sel_d  = wr_sel;
      hold_data_d = wr_data;
      req_seen_d  = req_sync;
    end

    if (apply) begin
      wr_ack_d = ~wr_ack_q;
      case (hold_sel_q)
        SEL_CNT:  cnt_d = hold_data_q;
        SEL_CTRL: begin
          cnt_en_d = hold_data_q[0];
`ifdef RTC_ALARM_EN
          irq_en_d = hold_data_q[1];
          if (hold_data_q[2]) alarm_flag_d = 1'b0;
`endif
        end
`ifdef RTC_ALARM_EN
        SEL_ALARM: alarm_cmp_d = hold_data_q;
`endif
        default: ;
      endcase
    end

`ifdef RTC_ALARM_EN
    // Set has priority over a same-edge write-1-to-clear
    if (cnt_q == alarm_cmp_q) alarm_flag_d = 1'b1;
`endif

    if (s_state_q == S_PUB) begin
      snap_data_d = cnt_q;
      snap_tgl_d  = ~snap_tgl_q;
    end
  end

  assign wr_ack_tgl = wr_ack_q;
  assign snap_data  = snap_data_q;
  assign snap_tgl   = snap_tgl_q;
`ifdef RTC_ALARM_EN
  assign alarm_irq  = alarm_flag_q & irq_en_q;
`else
  assign alarm_irq  = 1'b0;
`endif

endmodule
